sram_responder: RTL
===================

# sram_responder

Cycle-accurate responder for the core's external SRAM pin interface (18-bit word address, 16-bit data, active-low CE/WE/OE/LB/UB). It stands in for the external SRAM in the top-level and in benches, replacing the zero-latency data-memory model. It stores halfwords with byte-lane writes and returns read data after a programmable latency, with a busy/valid indication. It also raises a sticky protocol-error flag when the controller misbehaves.

## Interface
- ADDR_W, 12: number of implemented address bits; depth is 2^ADDR_W halfwords.
- READ_LAT, 1: read latency in clock cycles; legal range is 1..7.
- clk, in, 1: sole clock; all pins are sampled on the rising edge.
- reset, in, 1: reset, asynchronous and active-low.
- SRAM_ADDR, in, 18: halfword address.
- SRAM_D, in, 16: write data from the controller.
- SRAM_Q, out, 16: read data, registered.
- SRAM_CE_N, in, 1: chip enable, active-low.
- SRAM_WE_N, in, 1: write enable, active-low.
- SRAM_OE_N, in, 1: output enable, active-low.
- SRAM_LB_N, in, 1: lower byte lane [7:0] enable, active-low.
- SRAM_UB_N, in, 1: upper byte lane [15:8] enable, active-low.
- o_rvalid, out, 1: one-cycle pulse; SRAM_Q carries newly returned read data.
- o_busy, out, 1: read in flight; pins are ignored while high.
- o_err, out, 1: sticky protocol-error flag; cleared only by reset.

## Operation
- FSM states: IDLE, RD_WAIT.
- Pins are sampled only in IDLE. In RD_WAIT, pin activity is ignored.
- Commands decoded in IDLE when SRAM_CE_N=0:
  - WRITE: SRAM_WE_N=0.
    - LB_N=0 writes SRAM_D[7:0] into mem[addr][7:0].
    - UB_N=0 writes SRAM_D[15:8] into mem[addr][15:8].
    - Both lanes disabled: no memory change, no error.
    - FSM stays in IDLE, so back-to-back writes are accepted every cycle.
  - READ: SRAM_WE_N=1 and SRAM_OE_N=0.
    - Latch address and lane mask; load counter with READ_LAT; go to RD_WAIT.
  - CE_N=0, WE_N=1, OE_N=1: no operation.
  - SRAM_CE_N=1: no operation, whatever the other pins are.
- RD_WAIT:
  - Counter decrements each edge.
  - On the edge where it reaches 0, SRAM_Q is loaded with mem[latched addr], with disabled lanes forced to 0x00.
  - o_rvalid=1 for that one cycle; FSM returns to IDLE.
- SRAM_Q holds its value until the next read completes. Writes never change SRAM_Q.
- Address rule: only SRAM_ADDR[ADDR_W-1:0] indexes memory. If any bit in SRAM_ADDR[17:ADDR_W] is nonzero:
  - set o_err;
  - a write is dropped;
  - a read completes normally but returns 0x0000.
- WE_N=0 together with OE_N=0: the write is performed and o_err is set.
- In RD_WAIT, if CE_N=0 and SRAM_ADDR differs from the latched address, o_err is set. The read itself is unaffected.
- Memory contents are not reset and have no initial value requirement. Benches must write before they read.

## Timing
- Reset (asynchronous assert, synchronous release): SRAM_Q=0x0000, o_rvalid=0, o_busy=0, o_err=0, FSM=IDLE. Memory is preserved.
- Reset during RD_WAIT aborts the read; no o_rvalid is produced.
- Write sampled at edge k: data is visible to a read sampled at edge k+1.
- Read sampled at edge k:
  - o_busy=1 from after edge k until edge k+READ_LAT.
  - SRAM_Q and o_rvalid update at edge k+READ_LAT.
  - The next command is sampled at edge k+READ_LAT+1 at the earliest, so peak read throughput is one read per READ_LAT+1 cycles.
- o_busy is a registered output: 1 exactly when the FSM is in RD_WAIT.
- o_rvalid is never high while o_busy is high.
- All outputs are registered; there are no combinational paths from pins to outputs.

## Test plan
- Reset and idle: hold reset=0, then release with CE_N=1 for 10 cycles -> SRAM_Q=0, o_rvalid=0, o_busy=0, o_err=0 throughout.
- Byte-lane writes (READ_LAT=1):
  - full write of 0xBEEF to addr 0x005;
  - then LB-only write of 0x1234 to the same address;
  - then full read of 0x005 -> SRAM_Q=0xBE34 one edge after sampling, with a single o_rvalid pulse.
  - Then UB-only read -> SRAM_Q=0xBE00.
- Latency sweep: READ_LAT=3, write 0xA5A5 to 0x0FF, read 0x0FF at edge k -> o_busy high for 3 cycles, o_rvalid/SRAM_Q=0xA5A5 at edge k+3, next read accepted no earlier than edge k+4.
- Write-then-read same address: write 0x0001 to 0x010 at edge k, read 0x010 at edge k+1 -> returns 0x0001. A command presented during RD_WAIT is ignored: memory is unchanged, as checked by a later read.
- Protocol errors:
  - read of 0x20000 -> returns 0x0000, o_err=1, stays 1 until reset;
  - fresh reset, then WE_N=0 with OE_N=0 writing 0x7777 to 0x003 -> o_err=1, later read of 0x003 returns 0x7777.
- Reset mid-read: READ_LAT=5, reset asserted 2 cycles after read sampling -> o_busy drops immediately, no o_rvalid ever appears, SRAM_Q=0; a subsequent read returns the pre-reset memory contents.

Source files
------------

// File: rtl/sram_responder_if.sv
// SRAM pin bundle shared by the controller (master) and the responder (slave).
interface sram_responder_if;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_D;
  logic [15:0] SRAM_Q;
  logic        SRAM_CE_N;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic        SRAM_LB_N;
  logic        SRAM_UB_N;
  logic        o_rvalid;
  logic        o_busy;
  logic        o_err;

  modport master (
    output SRAM_ADDR, SRAM_D, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N,
    input  SRAM_Q, o_rvalid, o_busy, o_err
  );

  modport slave (
    input  SRAM_ADDR, SRAM_D, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N,
    output SRAM_Q, o_rvalid, o_busy, o_err
  );
endinterface

// File: rtl/sram_responder.sv
// Cycle-accurate external SRAM stand-in: byte-lane writes, reads returned after
// READ_LAT cycles with busy/valid, and a sticky protocol-error flag.
module sram_responder #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned READ_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  sram_responder_if.slave  bus
);

  // Bits of the 18-bit address above the implemented range.
  localparam logic [17:0] HiMask  = ~((18'd1 << ADDR_W) - 18'd1);
  localparam logic [2:0]  LatInit = 3'(READ_LAT);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [1:0]  lane_q, lane_d;     // {upper, lower} enabled lanes of the pending read
  logic [15:0] q_q, q_d;
  logic        rvalid_q, rvalid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [15:0] mem [2**ADDR_W];

  logic              cmd_act, cmd_wr, cmd_rd, pin_oob, lat_oob;
  logic              mem_we_lo, mem_we_hi;
  logic [ADDR_W-1:0] pin_idx;
  logic [15:0]       mem_word, rd_data;

  // Command decode from the sampled pins; only meaningful in StIdle.
  always_comb begin
    cmd_act   = (state_q == StIdle) && !bus.SRAM_CE_N;
    cmd_wr    = cmd_act && !bus.SRAM_WE_N;
    cmd_rd    = cmd_act && bus.SRAM_WE_N && !bus.SRAM_OE_N;
    pin_oob   = |(bus.SRAM_ADDR & HiMask);
    pin_idx   = bus.SRAM_ADDR[ADDR_W-1:0];
    mem_we_lo = cmd_wr && !pin_oob && !bus.SRAM_LB_N;
    mem_we_hi = cmd_wr && !pin_oob && !bus.SRAM_UB_N;
  end

  // Read data for the latched address, disabled lanes and out-of-range reads zeroed.
  always_comb begin
    lat_oob  = |(addr_q & HiMask);
    mem_word = mem[addr_q[ADDR_W-1:0]];
    rd_data  = 16'h0000;
    if (!lat_oob) begin
      rd_data[7:0]  = lane_q[0] ? mem_word[7:0]  : 8'h00;
      rd_data[15:8] = lane_q[1] ? mem_word[15:8] : 8'h00;
    end
  end

  // Next-state logic for the FSM, read pipeline and error flag.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    lane_d   = lane_q;
    q_d      = q_q;
    rvalid_d = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_rd) begin
          state_d = StRdWait;
          cnt_d   = LatInit;
          addr_d  = bus.SRAM_ADDR;
          lane_d  = {~bus.SRAM_UB_N, ~bus.SRAM_LB_N};
        end
        if ((cmd_wr || cmd_rd) && pin_oob) err_d = 1'b1;
        if (cmd_wr && !bus.SRAM_OE_N) err_d = 1'b1;
      end
      StRdWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d  = StIdle;
          q_d      = rd_data;
          rvalid_d = 1'b1;
        end
        // Controller must hold the address (or deselect) while a read is in flight.
        if (!bus.SRAM_CE_N && (bus.SRAM_ADDR != addr_q)) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRdWait);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      addr_q   <= 18'd0;
      lane_q   <= 2'b00;
      q_q      <= 16'h0000;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      lane_q   <= lane_d;
      q_q      <= q_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Storage array; deliberately not reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_lo) mem[pin_idx][7:0]  <= bus.SRAM_D[7:0];
    if (mem_we_hi) mem[pin_idx][15:8] <= bus.SRAM_D[15:8];
  end

  assign bus.SRAM_Q   = q_q;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_err    = err_q;

endmodule
